// File: rtl/cpu_trace_buffer.sv
// CPU instruction trace buffer: after a trigger it records qualified fetch-end
// events, then freezes and drains them oldest-first over a valid/ready port.
module cpu_trace_buffer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13,
  parameter int OP_W   = 3,
  parameter int DEPTH  = 16,
  parameter int MODE   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch,
  input  logic [ADDR_W-1:0]      pc_addr,
  input  logic [OP_W-1:0]        opcode,
  input  logic [ADDR_W-1:0]      ir_addr,
  input  logic [DATA_W-1:0]      data,
  input  logic                   halt,
  input  logic                   arm,
  input  logic [(2**OP_W)-1:0]   op_mask,
  input  logic [OP_W-1:0]        trig_op,
  input  logic                   trig_any,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      out_pc,
  output logic [OP_W-1:0]        out_op,
  output logic [ADDR_W-1:0]      out_ir,
  output logic [DATA_W-1:0]      out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic [1:0]             state,
  output logic [7:0]             lost
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 2 * ADDR_W + OP_W + DATA_W;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_CAPTURE = 2'b10,
    S_FROZEN  = 2'b11
  } state_t;

  state_t          st, st_nx;
  logic [PW-1:0]   wp, wp_nx, rp, rp_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [7:0]      lost_q, lost_nx;
  logic            fetch_q, halt_q;
  logic            wr_en, restart;
  logic            evt, qual, trig_hit, halt_rise, full;
  logic [EW-1:0]   mem [DEPTH];

  // An event is the falling edge of fetch; its fields are taken in that cycle.
  assign evt       = fetch_q & ~fetch;
  assign qual      = evt & op_mask[opcode];
  assign trig_hit  = qual & (trig_any | (opcode == trig_op));
  assign halt_rise = halt & ~halt_q;
  assign full      = (cnt == FULL);

  always_comb begin
    st_nx   = st;
    wp_nx   = wp;
    rp_nx   = rp;
    cnt_nx  = cnt;
    lost_nx = lost_q;
    wr_en   = 1'b0;
    restart = 1'b0;
    case (st)
      S_IDLE: restart = arm;
      S_ARMED: begin
        if (arm) begin
          restart = 1'b1;
        end else if (trig_hit) begin
          wr_en  = 1'b1;
          wp_nx  = wp + 1'b1;
          cnt_nx = ONE;
          st_nx  = halt_rise ? S_FROZEN : S_CAPTURE;
        end else if (halt_rise) begin
          st_nx = S_FROZEN;
        end
      end
      S_CAPTURE: begin
        if (arm) begin
          restart = 1'b1;
        end else begin
          if (qual) begin
            wr_en = 1'b1;
            wp_nx = wp + 1'b1;
            if (full) begin
              // Circular mode only: the oldest entry is dropped.
              rp_nx = rp + 1'b1;
              if (lost_q != 8'hFF) lost_nx = lost_q + 8'd1;
            end else begin
              cnt_nx = cnt + 1'b1;
              if (MODE == 0 && cnt == LAST) st_nx = S_FROZEN;
            end
          end
          // The same-cycle event (if any) is stored above before freezing.
          if (halt_rise) st_nx = S_FROZEN;
        end
      end
      S_FROZEN: begin
        if (cnt == '0) begin
          st_nx = S_IDLE;
        end else if (out_ready) begin
          rp_nx  = rp + 1'b1;
          cnt_nx = cnt - 1'b1;
          if (cnt == ONE) st_nx = S_IDLE;
        end
      end
      default: st_nx = S_IDLE;
    endcase
    if (restart) begin
      st_nx   = S_ARMED;
      wp_nx   = '0;
      rp_nx   = '0;
      cnt_nx  = '0;
      lost_nx = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= S_IDLE;
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      lost_q  <= '0;
      fetch_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      st      <= st_nx;
      wp      <= wp_nx;
      rp      <= rp_nx;
      cnt     <= cnt_nx;
      lost_q  <= lost_nx;
      fetch_q <= fetch;
      halt_q  <= halt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= {pc_addr, opcode, ir_addr, data};
  end

  // Readout handshake: out_valid/out_* hold steady until a cycle with
  // out_valid && out_ready, which pops the oldest entry on that clock edge.
  assign out_valid = (st == S_FROZEN) && (cnt != '0);
  assign {out_pc, out_op, out_ir, out_data} = out_valid ? mem[rp] : '0;

  assign count = cnt;
  assign state = st;
  assign lost  = lost_q;

endmodule

// File: doc/cpu_trace_buffer.md
CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

Interface
REQ-001 Parameter DATA_W, default 8: width of the data-bus sample.
REQ-002 Parameter ADDR_W, default 13: width of the PC and IR address samples.
REQ-003 Parameter OP_W, default 3: opcode width.
REQ-004 Parameter DEPTH, default 16: entry count, power of two, 2 to 256.
REQ-005 Parameter MODE, default 0: 0 = stop when full; 1 = circular, overwrite oldest, stop on halt.
REQ-006 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-007 Port rst, input, 1: reset, asynchronous and active-low.
REQ-008 Port fetch, input, 1: CPU fetch-phase flag.
REQ-009 Port pc_addr, input, ADDR_W: CPU program counter.
REQ-010 Port opcode, input, OP_W: current instruction opcode.
REQ-011 Port ir_addr, input, ADDR_W: instruction operand address.
REQ-012 Port data, input, DATA_W: CPU data bus.
REQ-013 Port halt, input, 1: CPU halt flag.
REQ-014 Port arm, input, 1: single-cycle pulse that starts a trace session.
REQ-015 Port op_mask, input, 2**OP_W: capture enable, one bit per opcode.
REQ-016 Port trig_op, input, OP_W: trigger opcode.
REQ-017 Port trig_any, input, 1: when 1, any qualified event triggers.
REQ-018 Port out_valid, output, 1: the readout entry is valid.
REQ-019 Port out_ready, input, 1: readout consumer accepts the entry.
REQ-020 Ports out_pc (ADDR_W), out_op (OP_W), out_ir (ADDR_W), out_data (DATA_W), all outputs: readout entry fields.
REQ-021 Port count, output, clog2(DEPTH)+1: number of stored entries.
REQ-022 Port state, output, 2: IDLE=00, ARMED=01, CAPTURE=10, FROZEN=11.
REQ-023 Port lost, output, 8: count of overwritten entries, saturates at 255.

Function
REQ-024 Event: fetch registered as fetch_q; an event occurs in any cycle where fetch_q=1 and fetch=0, and pc_addr, opcode, ir_addr and data are sampled in that same cycle.
REQ-025 Qualified event: an event with op_mask[opcode]=1; all other events are ignored in every state.
REQ-026 IDLE: events are ignored; arm moves to ARMED and clears count, write pointer, read pointer and lost.
REQ-027 ARMED: a qualified event with trig_any=1 or opcode==trig_op moves to CAPTURE, and that event is stored as entry 0.
REQ-028 ARMED: halt going 0->1 moves to FROZEN with count=0; FROZEN then exits to IDLE on the next cycle.
REQ-029 CAPTURE: each qualified event is written at the write pointer, which then advances modulo DEPTH; count updates on the cycle after the event.
REQ-030 MODE=0: the write that makes count equal to DEPTH moves to FROZEN, so no later event is stored.
REQ-031 MODE=1 when full: a new event overwrites the oldest entry, the read pointer advances, count stays at DEPTH, and lost increments (saturating at 255).
REQ-032 CAPTURE: halt going 0->1 moves to FROZEN; if a qualified event occurs in the same cycle, it is stored first.
REQ-033 arm in ARMED or CAPTURE restarts the session: pointers, count and lost are cleared, and the state becomes ARMED.
REQ-034 arm in FROZEN is ignored.
REQ-035 FROZEN: out_valid=1 if and only if count!=0; out_* present the entry at the read pointer (oldest first).
REQ-036 FROZEN: a transfer occurs when out_valid and out_ready are both 1; the read pointer advances and count decrements.
REQ-037 FROZEN: out_* and out_valid stay stable while out_ready=0.
REQ-038 FROZEN: the transfer that brings count to 0 moves to IDLE on the next edge.
REQ-039 out_valid is 0 in every state except FROZEN.
REQ-040 Pointer wrap: pointers wrap from DEPTH-1 to 0; count never exceeds DEPTH and never goes below 0.

Reset
REQ-041 rst=0 asynchronously forces: state=IDLE, count=0, lost=0, out_valid=0, pointers=0, fetch_q=0.
REQ-042 Reset forces out_pc, out_op, out_ir and out_data to 0.
REQ-043 Reset asserted mid-CAPTURE or mid-readout discards all stored entries.
REQ-044 Storage contents need no reset, but are never presented as valid after reset.

Verification (DEPTH=4, defaults otherwise)
REQ-045 Reset: assert rst=0 during CAPTURE with count=2 -> immediately state=00, count=0, out_valid=0, lost=0.
REQ-046 Trigger: op_mask=8'hFF, trig_op=5, arm, then events with opcodes 2, 5, 6, halt -> FROZEN, count=2, readout op=5 then op=6.
REQ-047 Stop mode: trig_any=1, 6 qualified events with pc 0,2,4,6,8,A -> FROZEN after the 4th event, count=4, readout pc 0,2,4,6.
REQ-048 Wrap mode (MODE=1): trig_any=1, 6 events with pc 0 through A, then halt -> count=4, lost=2, readout pc 4,6,8,A.
REQ-049 Filter and backpressure: op_mask=8'h04, events with opcodes 2,3,2,7, halt -> count=2; hold out_ready=0 for 3 cycles -> out_* unchanged; drain -> state=IDLE one cycle after the last transfer.
REQ-050 Simultaneous: in CAPTURE with count=1, a qualified event and a halt rise in the same cycle -> count=2 and state=FROZEN on the next cycle.
